// File: rtl/inst_writer.sv
// inst_writer: packs decoded instruction fields into 16-bit words.
// Words go to consecutive instruction-memory addresses starting at 0, and a
// small FIFO sits between the input handshake and the memory write port.
// A finish request drains the FIFO, appends a 16'h0000 terminator and parks
// the block in DONE until reset.
module inst_writer #(
  parameter int INST_WIDTH       = 16,
  parameter int INST_MEMORY_SIZE = 1024,
  parameter int ADDR_WIDTH       = 10,
  parameter int OPCODE_WIDTH     = 4,
  parameter int BUF_ID_WIDTH     = 2,
  parameter int MEM_LOC_WIDTH    = 10,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_WIDTH-1:0]  in_opcode,
  input  logic [BUF_ID_WIDTH-1:0]  in_buf_id,
  input  logic [MEM_LOC_WIDTH-1:0] in_mem_loc,
  input  logic                     finish,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [INST_WIDTH-1:0]    mem_wdata,
  output logic [ADDR_WIDTH:0]      inst_count,
  output logic                     full,
  output logic                     err,
  output logic                     done
);

  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int N_LEGAL  = 4;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_LD       = OPCODE_WIDTH'(4'b0010);
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_ST       = OPCODE_WIDTH'(4'b0011);
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_GEMM     = OPCODE_WIDTH'(4'b0100);
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_DRAINSYS = OPCODE_WIDTH'(4'b0101);

  localparam logic [N_LEGAL*OPCODE_WIDTH-1:0] LEGAL_OPS =
    {OPCODE_DRAINSYS, OPCODE_GEMM, OPCODE_ST, OPCODE_LD};

  // The last address is reserved for the terminator word.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(INST_MEMORY_SIZE - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_TERM,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  // FIFO storage and bookkeeping
  logic [INST_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      fifo_wp_reg;
  logic [PTR_W-1:0]      fifo_rp_reg;
  logic [CNT_W-1:0]      fifo_cnt_reg;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [INST_WIDTH-1:0] fifo_head;

  // Write-side registers
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH:0]   inst_count_reg;
  logic                  mem_we_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [INST_WIDTH-1:0] mem_wdata_reg;
  logic                  err_reg;

  // Handshake / control decode
  logic [N_LEGAL-1:0]    op_match;
  logic                  op_legal;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  discard;
  logic                  term_enter;
  logic                  full_now;
  logic [INST_WIDTH-1:0] in_word;

  // One comparator per legal opcode; any hit makes the instruction legal.
  for (genvar gi = 0; gi < N_LEGAL; gi++) begin : g_op_match
    assign op_match[gi] = (in_opcode == LEGAL_OPS[gi*OPCODE_WIDTH +: OPCODE_WIDTH]);
  end

  assign op_legal   = |op_match;
  assign in_word    = INST_WIDTH'({in_opcode, in_buf_id, in_mem_loc});
  assign fifo_empty = (fifo_cnt_reg == '0);
  assign fifo_full  = (fifo_cnt_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_head  = fifo_mem[fifo_rp_reg];
  assign full_now   = (wr_ptr_reg == LAST_ADDR);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state plus handshake/pop/discard decisions, all from registered state.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    pop        = 1'b0;
    discard    = 1'b0;
    case (state_reg)
      S_RUN: begin
        in_ready = !fifo_full;
        pop      = !fifo_empty && !full_now;
        if (finish) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        pop = !fifo_empty && !full_now;
        if (fifo_empty) begin
          state_next = S_TERM;
        end else if (full_now) begin
          // No room left: whatever is still queued can never be written.
          discard    = 1'b1;
          state_next = S_TERM;
        end
      end
      S_TERM: begin
        state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_DONE;
      end
      default: begin
        state_next = S_RUN;
      end
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign push       = accept && op_legal;
  // The terminator is registered on the edge that enters TERM so that
  // mem_we is high exactly during the TERM cycle and low again in DONE.
  assign term_enter = (state_next == S_TERM);

  // FIFO payload: plain array, written at the write pointer only on a push.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[fifo_wp_reg] <= in_word;
    end
  end

  // FIFO pointers and occupancy; a discard empties the queue in one step.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wp_reg  <= '0;
      fifo_rp_reg  <= '0;
      fifo_cnt_reg <= '0;
    end else if (discard) begin
      fifo_rp_reg  <= fifo_wp_reg;
      fifo_cnt_reg <= '0;
    end else begin
      if (push) begin
        fifo_wp_reg <= fifo_wp_reg + PTR_W'(1);
      end
      if (pop) begin
        fifo_rp_reg <= fifo_rp_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
      end
    end
  end

  // Memory write port, write pointer, instruction count and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      inst_count_reg <= '0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      mem_we_reg <= pop || term_enter;
      if (pop) begin
        mem_addr_reg   <= wr_ptr_reg;
        mem_wdata_reg  <= fifo_head;
        wr_ptr_reg     <= wr_ptr_reg + ADDR_WIDTH'(1);
        inst_count_reg <= inst_count_reg + (ADDR_WIDTH+1)'(1);
      end else if (term_enter) begin
        // Terminator: written at the current pointer, not counted.
        mem_addr_reg  <= wr_ptr_reg;
        mem_wdata_reg <= '0;
      end
      if ((accept && !op_legal) || discard) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign inst_count = inst_count_reg;
  assign full       = full_now;
  assign err        = err_reg;
  assign done       = (state_reg == S_DONE);

endmodule
